fifo_rd_stream: RTL and testbench

Read-side output stage of the asynchronous FIFO, sitting directly downstream of the read-domain empty/pointer logic and the dual-port memory's registered read port. It turns the pointer-based read interface (empty flag in, read enable out, one-cycle memory read latency) into a valid/ready stream for the consumer. A 2-entry output buffer with in-flight tracking sustains one word per cycle and never drops or duplicates a word under back-pressure.

---
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side output stage of the asynchronous FIFO. Converts the
//               pointer-based read interface (empty flag in, read enable out,
//               one-cycle registered memory read latency) into a valid/ready
//               stream. A 2-entry output buffer plus an in-flight marker
//               sustains one word per cycle and never drops or duplicates a
//               word under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_empty_flag,
    output logic               o_rd_en,
    input  logic [D_WIDTH-1:0] i_mem_rdata,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic [D_WIDTH-1:0] o_m_data,
    output logic [1:0]         o_level
);

    localparam int C_DEPTH = 2;

    // In-flight marker: a pop last cycle means i_mem_rdata is valid now.
    logic               r_inflight;
    // Buffer pointers (one bit each, natural wrap 1 -> 0) and occupancy.
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_cnt;
    logic [D_WIDTH-1:0] r_entry [C_DEPTH];

    logic               w_acc;
    logic               w_pop;
    logic [2:0]         w_occ_next;

    // Consumer handshake and the occupancy the buffer will have next cycle.
    // Three bits keep the subtraction safe; acc implies cnt >= 1 so the
    // result never actually goes negative.
    always_comb begin
        w_acc      = o_m_valid & i_m_ready;
        w_occ_next = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_acc};
    end

    // Pop request: only when the FIFO has data and, counting the word that
    // would arrive next cycle, the buffer can never exceed two entries.
    // Because the bound uses the same-cycle accept, a full buffer that is
    // being drained can request a new word in that very cycle.
    always_comb begin
        o_rd_en = ~rst & ~i_empty_flag & (w_occ_next <= 3'd1);
        w_pop   = o_rd_en & ~i_empty_flag;
    end

    // Buffer state: capture returning words, advance the read side on
    // accept, track occupancy. Reset discards anything still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
            r_entry[0] <= '0;
            r_entry[1] <= '0;
        end else begin
            r_inflight <= w_pop;
            if (r_inflight) begin
                r_entry[r_wptr] <= i_mem_rdata;
                r_wptr          <= ~r_wptr;
            end
            if (w_acc) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= w_occ_next[1:0];
        end
    end

    // Stream outputs come straight from the buffer registers.
    always_comb begin
        o_m_valid = (r_cnt != 2'd0);
        o_m_data  = r_entry[r_rptr];
        o_level   = r_cnt;
    end

`ifndef SYNTHESIS
    // Occupancy bound and no-pop-on-empty guarantee.
    always @(posedge clk) begin
        if (!rst) begin
            assert (r_cnt <= 2'd2)
                else $error("fifo_rd_stream: occupancy above 2");
            assert (!(o_rd_en && i_empty_flag))
                else $error("fifo_rd_stream: read enable while empty");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream. Models the upstream
//               FIFO (source queue, empty flag, one-cycle memory latency) and
//               scores delivered words against the order they were popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_empty_flag = 1'b1;
    logic       i_m_ready = 1'b0;
    logic [7:0] i_mem_rdata = 8'h00;
    logic       o_rd_en;
    logic       o_m_valid;
    logic [7:0] o_m_data;
    logic [1:0] o_level;

    fifo_rd_stream #(.D_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_empty_flag (i_empty_flag),
        .o_rd_en      (o_rd_en),
        .i_mem_rdata  (i_mem_rdata),
        .o_m_valid    (o_m_valid),
        .i_m_ready    (i_m_ready),
        .o_m_data     (o_m_data),
        .o_level      (o_level)
    );

    always #5 clk = ~clk;

    logic [7:0] src_q [$];   // words still in the upstream FIFO
    logic [7:0] exp_q [$];   // popped words awaiting delivery, in order
    int         tests  = 0;
    int         fails  = 0;
    int         n_pop  = 0;
    int         n_deliv = 0;
    bit         s_rd_en;
    bit         s_valid;
    logic [7:0] s_data;
    logic [1:0] s_level;
    bit         hold = 1'b0;
    logic [7:0] hold_data;
    logic [7:0] junk = 8'hC3;  // what mem_rdata shows when no word returns

    // One clock cycle of the upstream model plus per-cycle checks.
    task automatic cyc(input bit rdy, input bit force_empty);
        bit         pop;
        logic [7:0] w;
        i_m_ready    = rdy;
        i_empty_flag = force_empty || (src_q.size() == 0);
        @(negedge clk);
        s_rd_en = o_rd_en;
        s_valid = o_m_valid;
        s_data  = o_m_data;
        s_level = o_level;
        tests++;
        if (o_rd_en === 1'b1 && i_empty_flag) begin
            fails++; $display("FAIL rd_en_on_empty: rd_en=%b empty_flag=1", o_rd_en);
        end
        tests++;
        if (o_level > 2'd2 || $isunknown(o_level)) begin
            fails++; $display("FAIL level_bound: level=%0d required<=2", o_level);
        end
        tests++;
        if (o_m_valid !== (o_level != 2'd0)) begin
            fails++; $display("FAIL valid_vs_level: valid=%b level=%0d", o_m_valid, o_level);
        end
        if (hold) begin
            tests++;
            if (o_m_valid !== 1'b1 || o_m_data !== hold_data) begin
                fails++;
                $display("FAIL stall_stable: valid=%b data=%h required valid=1 data=%h",
                         o_m_valid, o_m_data, hold_data);
            end
        end
        hold = 1'b0;
        if (!rst && o_m_valid === 1'b1) begin
            if (rdy) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL unexpected_word: got %h with nothing expected", o_m_data);
                end else begin
                    w = exp_q.pop_front();
                    if (o_m_data !== w) begin
                        fails++; $display("FAIL order: got %h required %h", o_m_data, w);
                    end
                    n_deliv++;
                end
            end else begin
                hold      = 1'b1;
                hold_data = o_m_data;
            end
        end
        pop = (o_rd_en === 1'b1) && !i_empty_flag;
        if (pop) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
            n_pop++;
        end
        @(posedge clk);
        #1;
        i_mem_rdata = pop ? w : junk;
        if (rst) begin
            exp_q.delete();
            hold = 1'b0;
        end
    endtask

    // Run with the consumer always ready until everything popped is delivered.
    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || o_level != 2'd0) && k < 200) begin
            cyc(1'b1, 1'b0);
            k++;
        end
        tests++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: pending=%0d source=%0d required 0/0",
                     exp_q.size(), src_q.size());
        end
    endtask

    task automatic test_reset();
        src_q.push_back(8'h5A);
        rst = 1'b1;
        repeat (3) begin
            cyc(1'b0, 1'b0);
            tests++;
            if ({s_rd_en, s_valid, s_level} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_outputs: rd_en=%b valid=%b level=%0d required 0/0/0",
                         s_rd_en, s_valid, s_level);
            end
        end
        tests++;
        if (o_m_data !== 8'h00) begin
            fails++; $display("FAIL reset_data: data=%h required 00", o_m_data);
        end
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        tests++;
        if (s_rd_en !== 1'b1) begin
            fails++; $display("FAIL rd_en_after_reset: rd_en=%b required 1", s_rd_en);
        end
        drain();
    endtask

    task automatic test_single();
        repeat (2) begin
            cyc(1'b1, 1'b0);
            tests++;
            if (s_rd_en !== 1'b0) begin
                fails++; $display("FAIL idle_rd_en: rd_en=%b required 0", s_rd_en);
            end
        end
        src_q.push_back(8'hA5);
        cyc(1'b1, 1'b0);
        tests++;
        if (s_rd_en !== 1'b1) begin
            fails++; $display("FAIL single_pop: rd_en=%b required 1", s_rd_en);
        end
        cyc(1'b1, 1'b0);
        tests++;
        if (s_valid !== 1'b0 || s_rd_en !== 1'b0) begin
            fails++; $display("FAIL single_t1: valid=%b rd_en=%b required 0/0", s_valid, s_rd_en);
        end
        cyc(1'b1, 1'b0);
        tests++;
        if (s_valid !== 1'b1 || s_data !== 8'hA5) begin
            fails++; $display("FAIL single_t2: valid=%b data=%h required 1/a5", s_valid, s_data);
        end
        cyc(1'b1, 1'b0);
        tests++;
        if (s_valid !== 1'b0 || s_level !== 2'd0 || s_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL single_t3: valid=%b level=%0d rd_en=%b required 0/0/0",
                     s_valid, s_level, s_rd_en);
        end
    endtask

    task automatic test_stream();
        int p0 = n_pop;
        int d0 = n_deliv;
        int vcnt = 0, vrun = 0, vmax = 0, prun = 0, pmax = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        repeat (20) begin
            cyc(1'b1, 1'b0);
            if (s_valid) begin vcnt++; vrun++; if (vrun > vmax) vmax = vrun; end
            else vrun = 0;
            if (s_rd_en) begin prun++; if (prun > pmax) pmax = prun; end
            else prun = 0;
        end
        tests++;
        if (n_pop - p0 != 16 || pmax != 16) begin
            fails++; $display("FAIL stream_pops: pops=%0d run=%0d required 16/16", n_pop - p0, pmax);
        end
        tests++;
        if (vcnt != 16 || vmax != 16) begin
            fails++; $display("FAIL stream_valid: cycles=%0d run=%0d required 16/16", vcnt, vmax);
        end
        tests++;
        if (n_deliv - d0 != 16) begin
            fails++; $display("FAIL stream_count: delivered=%0d required 16", n_deliv - d0);
        end
    endtask

    task automatic test_backpressure();
        int d0 = n_deliv;
        int maxlvl = 0;
        for (int i = 0; i < 8; i++) src_q.push_back(8'h80 + 8'(i));
        for (int c = 0; c < 10; c++) begin
            cyc(c < 4, 1'b0);
            if (int'(s_level) > maxlvl) maxlvl = int'(s_level);
            if (c >= 4) begin
                tests++;
                if (s_rd_en !== 1'b0) begin
                    fails++; $display("FAIL stall_rd_en: cycle=%0d rd_en=%b required 0", c, s_rd_en);
                end
            end
        end
        tests++;
        if (maxlvl != 2) begin
            fails++; $display("FAIL stall_level: max level=%0d required 2", maxlvl);
        end
        cyc(1'b1, 1'b0);
        tests++;
        if (s_rd_en !== 1'b1) begin
            fails++; $display("FAIL resume_rd_en: rd_en=%b required 1", s_rd_en);
        end
        drain();
        tests++;
        if (n_deliv - d0 != 8) begin
            fails++; $display("FAIL bp_count: delivered=%0d required 8", n_deliv - d0);
        end
    endtask

    task automatic test_random();
        int d0 = n_deliv;
        int k  = 0;
        for (int i = 0; i < 1000; i++) src_q.push_back(8'((i * 7 + 3) & 8'hFF));
        while (n_deliv - d0 < 1000 && k < 20000) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            k++;
        end
        tests++;
        if (n_deliv - d0 != 1000 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL random_count: delivered=%0d pending=%0d required 1000/0",
                     n_deliv - d0, exp_q.size());
        end
    endtask

    // Occupancy plus in-flight never exceeds two, so the fullest state that
    // still has a word in flight is one buffered word plus one returning.
    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) src_q.push_back(8'h40 + 8'(i));
        repeat (4) cyc(1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        tests++;
        if (s_level !== 2'd1 || s_rd_en !== 1'b0) begin
            fails++; $display("FAIL pre_reset_state: level=%0d rd_en=%b required 1/0", s_level, s_rd_en);
        end
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        tests++;
        if (s_valid !== 1'b0 || s_level !== 2'd0) begin
            fails++; $display("FAIL post_reset: valid=%b level=%0d required 0/0", s_valid, s_level);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
